alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 8-bit, 2-bit-select ALU (S: 0=AND, 1=OR, 2=XOR, 3=NOT A).
- Collects a 3-byte command frame (opcode, A, B) from a byte stream with a valid/ready handshake.
- Holds the frame on the ALU operand/select inputs, waits a fixed settle time, then captures IS/cout into a small result buffer.
- The result buffer is drained by a valid/ready consumer.

Parameters:
- WIDTH, 8, operand/result width.
- SETTLE, 1, clock cycles the ALU inputs are held before capture (1..15).
- OBUF_DEPTH, 2, result buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  command byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- alu_a  out  WIDTH  ALU operand A (registered).
- alu_b  out  WIDTH  ALU operand B (registered).
- alu_s  out  2  ALU select (registered).
- alu_is  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry out.
- res_data  out  WIDTH  buffered result, head entry.
- res_cout  out  1  buffered carry, head entry.
- res_valid  out  1  result buffer non-empty.
- res_ready  in  1  consumer accepts the head entry.
- busy  out  1  FSM not in S_OP.
- frame_err  out  1  one-cycle pulse on a rejected opcode byte.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_OP; alu_a=0, alu_b=0, alu_s=0.
  - Buffer empty: res_valid=0, res_data=0, res_cout=0.
  - frame_err=0, busy=0, settle counter=0.
  - Reset mid-frame or mid-capture discards the partial frame and all buffered results.
- Byte transfer occurs on any edge where in_valid=1 and in_ready=1. in_ready=1 only in S_OP, S_A and S_B.
- Opcode byte format: [7:4] must be 4'hA (sync nibble); [3:2] are ignored; [1:0] are the select.
- S_OP:
  - Accepted byte with [7:4]=4'hA: alu_s<=byte[1:0], go to S_A.
  - Otherwise: drop the byte, pulse frame_err for exactly 1 cycle, stay in S_OP.
- S_A: accepted byte: alu_a<=byte, go to S_B.
- S_B: accepted byte: alu_b<=byte, load the settle counter with SETTLE, go to S_EXEC.
- S_EXEC:
  - Counter decrements each cycle; go to S_CAP on the edge where the counter reaches 0.
  - alu_a/alu_b/alu_s are stable from the S_B acceptance edge until the next frame's opcode is accepted.
- S_CAP:
  - Buffer not full: write {alu_cout, alu_is} into the buffer, go to S_OP.
  - Buffer full: stay in S_CAP (ALU inputs held) until an entry is popped.
- Latency: with an empty buffer, res_valid rises SETTLE+1 edges after the S_B acceptance edge (2 edges at the default).
- Result buffer:
  - FIFO with OBUF_DEPTH entries; pointers wrap modulo OBUF_DEPTH; occupancy counter has log2(OBUF_DEPTH)+1 bits.
  - Pop occurs on res_valid & res_ready.
  - Push and pop in the same cycle: both happen, occupancy unchanged. This holds when full, so S_CAP completes that cycle.
  - res_data/res_cout are valid only while res_valid=1.
- No arithmetic is performed in this block. Widths pass through unchanged; cout is not reinterpreted.
- alu_s and the outputs are held steady while the buffer is full and the consumer stalls. No result is ever dropped or duplicated.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND=2'd0, ALU_OR=2'd1, ALU_XOR=2'd2, ALU_NOTA=2'd3.
  - SYNC_NIBBLE=4'hA.
  - The FSM state encoding S_OP, S_A, S_B, S_EXEC, S_CAP.
- One sub-module, alu_res_fifo: a WIDTH+1-bit synchronous FIFO with push/pop/full/empty and the same clk/rst_n.

Test Plan:
- Frames {0xA0,0x0F,0x05}, {0xA1,0x0F,0x05}, {0xA2,0x0F,0x05}, {0xA3,0x0F,0x05}, sent back-to-back with the ALU connected and res_ready=1 -> res_data 0x05, 0x0F, 0x0A, 0xF0 in order; each res_valid exactly SETTLE+1 edges after the B byte; res_cout equals alu_cout at the capture edge.
- Byte 0x33 sent in S_OP, then frame {0xA1,0xF0,0x0C} -> frame_err pulses one cycle; no result for 0x33; single result 0xFC.
- res_ready=0, three frames sent -> two results buffered; the third frame stalls in S_CAP with in_ready=0 and alu_* held. Raise res_ready -> results come out in order with no loss; in_ready returns after the third capture.
- Buffer full while S_CAP waits; assert res_ready for one cycle -> pop and push on the same edge; occupancy stays 2; FSM reaches S_OP.
- rst_n pulsed low asynchronously (between edges) after the A byte, and again with 1 result buffered -> immediate res_valid=0, alu_*=0, state S_OP; next full frame processes normally.
- in_valid toggled randomly for 1-3 cycle gaps within a frame -> identical results to gap-free operation; no byte is accepted while in_ready=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes, the
// opcode sync nibble and the issue FSM state encoding.
package alu_pkg;

  // ALU select codes driven on alu_s
  localparam logic [1:0] ALU_AND  = 2'd0;
  localparam logic [1:0] ALU_OR   = 2'd1;
  localparam logic [1:0] ALU_XOR  = 2'd2;
  localparam logic [1:0] ALU_NOTA = 2'd3;

  // Upper nibble every opcode byte must carry to be accepted
  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_CAP  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO holding captured ALU results ({cout, result}).
// Ports:
//   clk, rst_n      clock, async active-low reset (clears pointers and storage)
//   push, wdata     write request and data
//   pop             read request; head advances on the same edge
//   rdata           head entry (zero when empty after reset)
//   full, empty     occupancy flags
// A push while full is accepted when a pop happens on the same edge.
module alu_res_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for an external 8-bit logic ALU. Collects an
// (opcode, A, B) byte frame, drives the ALU inputs, waits SETTLE cycles
// and captures {alu_cout, alu_is} into a result FIFO.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_data/in_valid/in_ready        command byte stream
//   alu_a/alu_b/alu_s                registered ALU inputs
//   alu_is/alu_cout                  ALU result inputs
//   res_data/res_cout/res_valid/res_ready  result stream (FIFO head)
//   busy                             FSM away from S_OP
//   frame_err                        one-cycle pulse on a rejected opcode byte
//
// state  | meaning
// S_OP   | waiting for opcode byte (sync nibble checked)
// S_A    | waiting for operand A byte
// S_B    | waiting for operand B byte
// S_EXEC | ALU inputs settling, counter running down
// S_CAP  | capture result into FIFO, held while FIFO full
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE     = 1,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_is,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             frame_err
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   cnt;
  logic [3:0]   cnt_nxt;
  logic         load_s;
  logic         load_a;
  logic         load_b;
  logic         err_nxt;
  logic         accept;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [WIDTH:0] fifo_rdata;

  assign in_ready  = (state == S_OP) || (state == S_A) || (state == S_B);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_OP);
  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign res_data  = fifo_rdata[WIDTH-1:0];
  assign res_cout  = fifo_rdata[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_OP;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_s    = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    case (state)
      S_OP: begin
        if (accept) begin
          if (in_data[7:4] == SYNC_NIBBLE) begin
            load_s    = 1'b1;
            state_nxt = S_A;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_A: begin
        if (accept) begin
          load_a    = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (accept) begin
          load_b    = 1'b1;
          cnt_nxt   = SETTLE_C;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // Leave on the edge where the counter hits zero; a zero count
        // (never loaded that way in normal use) also exits safely.
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = S_CAP;
      end
      S_CAP: begin
        // A pop on the same edge frees the slot, so capture completes even when full.
        if (!full || pop) begin
          push      = 1'b1;
          state_nxt = S_OP;
        end
      end
      default: state_nxt = S_OP;
    endcase
  end

  // Operand registers stay put until the next accepted opcode/operand byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
    end else begin
      if (load_s) alu_s <= in_data[1:0];
      if (load_a) alu_a <= in_data;
      if (load_b) alu_b <= in_data;
    end
  end

  alu_res_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (OBUF_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({alu_cout, alu_is}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 1;
  localparam int DEPTH  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_a, alu_b, alu_is;
  logic [1:0] alu_s;
  logic       alu_cout;
  logic [7:0] res_data;
  logic       res_cout, res_valid;
  logic       res_ready = 1'b0;
  logic       busy, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_edge = 0;
  bit lat_en = 1'b0;
  bit prev_valid = 1'b0;
  logic [8:0] exp_q[$];

  alu_issue_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_is(alu_is), .alu_cout(alu_cout), .res_data(res_data),
    .res_cout(res_cout), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .frame_err(frame_err)
  );

  // External ALU model
  function automatic logic [7:0] alu_f(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Arbitrary carry so res_cout carries distinguishable values
  function automatic logic cout_f(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    return a[7] ^ b[0] ^ s[0];
  endfunction

  assign alu_is   = alu_f(alu_s, alu_a, alu_b);
  assign alu_cout = cout_f(alu_s, alu_a, alu_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result monitor / scoreboard, sampled mid low phase
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (res_valid && !prev_valid && lat_en)
        chk("latency", 32'(cyc - b_edge), 32'(SETTLE + 1));
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'({res_cout, res_data}), 32'h1ff_ffff);
        else chk("result", 32'({res_cout, res_data}), 32'(exp_q.pop_front()));
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    bit done;
    done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else @(negedge clk);
    end
    chk("accept_timeout", 32'(done), 32'd1);
    #1 b_edge = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_res, input bit gaps);
    exp_q.push_back({cout_f(op[1:0], a, b), exp_res});
    if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(op);
    if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(a);
    if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(b);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) done = 1'b1;
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'({res_cout, res_data}), 32'd0);
    chk("rst_alu", 32'({alu_s, alu_a, alu_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit done;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_alu", 32'({alu_s, alu_a, alu_b}), 32'd0);
    chk("reset_res", 32'({res_cout, res_data}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back frames, all four selects
    res_ready = 1'b1;
    lat_en = 1'b1;
    send_frame(8'hA0, 8'h0F, 8'h05, 8'h05, 1'b0);
    send_frame(8'hA1, 8'h0F, 8'h05, 8'h0F, 1'b0);
    send_frame(8'hA2, 8'h0F, 8'h05, 8'h0A, 1'b0);
    send_frame(8'hA3, 8'h0F, 8'h05, 8'hF0, 1'b0);
    wait_drain();

    // Rejected opcode byte then a good frame
    send_byte(8'h33);
    chk("frame_err_pulse", 32'(frame_err), 32'd1);
    chk("frame_err_state", 32'(busy), 32'd0);
    @(negedge clk);
    chk("frame_err_clear", 32'(frame_err), 32'd0);
    send_frame(8'hA1, 8'hF0, 8'h0C, 8'hFC, 1'b0);
    wait_drain();

    // Stalled consumer: two buffered, third held in capture
    lat_en = 1'b0;
    res_ready = 1'b0;
    send_frame(8'hA0, 8'h0F, 8'h05, 8'h05, 1'b0);
    send_frame(8'hA1, 8'h3C, 8'h0F, 8'h3F, 1'b0);
    send_frame(8'hA3, 8'h55, 8'h00, 8'hAA, 1'b0);
    repeat (4) @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_alu_held", 32'({alu_s, alu_a, alu_b}), 32'({2'd3, 8'h55, 8'h00}));
    chk("stall_head", 32'({res_valid, res_data}), 32'({1'b1, 8'h05}));
    // Offer a byte while not ready; it must not be taken
    in_data = 8'hA2;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("stall_alu_s_kept", 32'(alu_s), 32'd3);
    // Single-cycle pop while full: push and pop on the same edge
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("simul_busy", 32'(busy), 32'd0);
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    chk("simul_res_valid", 32'(res_valid), 32'd1);
    chk("simul_alu_s", 32'(alu_s), 32'd3);
    repeat (2) @(negedge clk);
    chk("simul_head", 32'(res_data), 32'h3F);
    res_ready = 1'b1;
    wait_drain();
    chk("post_drain_empty", 32'(res_valid), 32'd0);

    // Async reset after the A byte
    lat_en = 1'b1;
    send_byte(8'hA2);
    send_byte(8'h33);
    pulse_reset();
    send_frame(8'hA2, 8'h3C, 8'h0F, 8'h33, 1'b0);
    wait_drain();

    // Async reset with one result buffered
    res_ready = 1'b0;
    send_frame(8'hA0, 8'hFF, 8'h81, 8'h81, 1'b0);
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (res_valid) done = 1'b1;
    end
    chk("buffered_before_reset", 32'(done), 32'd1);
    pulse_reset();
    res_ready = 1'b1;
    send_frame(8'hA3, 8'h5A, 8'h00, 8'hA5, 1'b0);
    wait_drain();

    // Random gaps inside frames
    send_frame(8'hA0, 8'h0F, 8'h05, 8'h05, 1'b1);
    send_frame(8'hA1, 8'h0F, 8'h05, 8'h0F, 1'b1);
    send_frame(8'hA2, 8'h0F, 8'h05, 8'h0A, 1'b1);
    send_frame(8'hA7, 8'h0F, 8'h05, 8'hF0, 1'b1);
    wait_drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
